// File: rtl/but_wing_seq.sv
// Stage/butterfly sequencer for a radix-2 in-place DIT FFT around but_wing.
// Issues one butterfly at most every other cycle, generating the sample-RAM
// read pair and twiddle address. It remembers each butterfly's address pair
// until both results come back, and then steers the write-back addresses.
// Each stage drains completely before the next stage reads.
module but_wing_seq #(
  parameter int LOG2_N    = 3,
  parameter int P_RD_LAT  = 2,
  parameter int P_MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fft_start,
  output logic              fft_busy,
  output logic              fft_done,
  output logic              rd_en,
  output logic [LOG2_N-1:0] rd_addr_a,
  output logic [LOG2_N-1:0] rd_addr_b,
  output logic [LOG2_N-2:0] twdl_addr,
  output logic              but_sample_rdy,
  input  logic              but_res_rdy,
  output logic              wr_en,
  output logic [LOG2_N-1:0] wr_addr,
  input  logic              but_ovrflw,
  input  logic              but_underflw,
  output logic              seq_err
);

  localparam int HALF = 1 << (LOG2_N - 1);
  localparam int SW   = $clog2(LOG2_N + 1);
  localparam int QD   = 8;

  localparam logic [LOG2_N-1:0] J_LAST  = LOG2_N'(HALF - 1);
  localparam logic [SW-1:0]     S_LAST  = SW'(LOG2_N - 1);
  localparam logic [3:0]        MAX_OUT = 4'(P_MAX_OUT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [SW-1:0]       stage;
  logic [LOG2_N-1:0]   bfly;
  logic                issued_last;
  logic [3:0]          outstanding;
  logic [2:0]          q_wr_ptr;
  logic [2:0]          q_rd_ptr;
  logic [3:0]          q_cnt;
  logic [LOG2_N-1:0]   q_a [QD];
  logic [LOG2_N-1:0]   q_b [QD];
  logic                beat_b;
  logic [P_RD_LAT-1:0] rd_dly;

  logic              start_acc;
  logic              issue;
  logic              drained;
  logic              q_empty;
  logic              pop;
  logic              err_now;
  logic [LOG2_N-1:0] span;
  logic [LOG2_N-1:0] grp;
  logic [LOG2_N-1:0] pos;
  logic [LOG2_N-1:0] addr_a;
  logic [LOG2_N-1:0] addr_b;
  logic [LOG2_N-2:0] tw;

  assign start_acc = (state == IDLE) && fft_start;
  assign q_empty   = (q_cnt == 4'd0);
  assign issue     = (state == RUN) && (outstanding < MAX_OUT) && !issued_last;
  assign drained   = (outstanding == 4'd0) && q_empty;
  assign pop       = but_res_rdy && !q_empty && beat_b;
  assign err_now   = (but_res_rdy && q_empty) || but_ovrflw || but_underflw;

  assign but_sample_rdy = rd_dly[P_RD_LAT-1];

  // Butterfly j of stage s: A/B are span apart inside group j>>s, twiddle scales with pos
  always_comb begin
    span   = LOG2_N'(1) << stage;
    grp    = bfly >> stage;
    pos    = bfly & (span - LOG2_N'(1));
    addr_a = (grp << (stage + 1'b1)) | pos;
    addr_b = addr_a + span;
    tw     = (LOG2_N-1)'(pos << (S_LAST - stage));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: run a stage, drain it, then advance or finish
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fft_start) state_nxt = RUN;
      RUN:   if (issue && (bfly == J_LAST)) state_nxt = DRAIN;
      DRAIN: if (drained) state_nxt = (stage == S_LAST) ? DONE : RUN;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; write address follows the head of the queue and the beat toggle
  always_comb begin
    fft_busy  = (state != IDLE);
    fft_done  = (state == DONE);
    rd_en     = issue;
    rd_addr_a = issue ? addr_a : '0;
    rd_addr_b = issue ? addr_b : '0;
    twdl_addr = issue ? tw : '0;
    wr_en     = but_res_rdy;
    wr_addr   = '0;
    if (but_res_rdy && !q_empty) wr_addr = beat_b ? q_b[q_rd_ptr] : q_a[q_rd_ptr];
  end

  // Stage and butterfly counters, plus the one-issue-per-two-cycles pacing flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage       <= '0;
      bfly        <= '0;
      issued_last <= 1'b0;
    end else begin
      issued_last <= issue;
      if (start_acc) begin
        stage <= '0;
        bfly  <= '0;
      end else if (issue) begin
        bfly <= bfly + 1'b1;
      end else if ((state == DRAIN) && drained && (stage != S_LAST)) begin
        stage <= stage + 1'b1;
        bfly  <= '0;
      end
    end
  end

  // Butterflies in flight: up on issue, down when the second result is written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= 4'd0;
    end else begin
      case ({issue, pop})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Address queue bookkeeping and result beat toggle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_wr_ptr <= 3'd0;
      q_rd_ptr <= 3'd0;
      q_cnt    <= 4'd0;
      beat_b   <= 1'b0;
    end else begin
      if (issue) q_wr_ptr <= q_wr_ptr + 1'b1;
      if (pop)   q_rd_ptr <= q_rd_ptr + 1'b1;
      case ({issue, pop})
        2'b10:   q_cnt <= q_cnt + 4'd1;
        2'b01:   q_cnt <= q_cnt - 4'd1;
        default: q_cnt <= q_cnt;
      endcase
      if (but_res_rdy && !q_empty) beat_b <= !beat_b;
    end
  end

  // Queue storage; only entries between the pointers are ever read
  always_ff @(posedge clk) begin
    if (issue) begin
      q_a[q_wr_ptr] <= addr_a;
      q_b[q_wr_ptr] <= addr_b;
    end
  end

  // Read strobe delayed to line up with sample and twiddle data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_dly <= '0;
    else        rd_dly <= (rd_dly << 1) | P_RD_LAT'(issue);
  end

  // Sticky error flag, cleared by an accepted start unless an error occurs in that cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         seq_err <= 1'b0;
    else if (err_now)   seq_err <= 1'b1;
    else if (start_acc) seq_err <= 1'b0;
  end

endmodule

// File: tb/tb_but_wing_seq.sv
// Scoreboard bench for but_wing_seq with a behavioural but_wing result model.
module tb_but_wing_seq;

  localparam int LOG2_N    = 3;
  localparam int N         = 1 << LOG2_N;
  localparam int HALF      = N / 2;
  localparam int P_RD_LAT  = 2;
  localparam int P_MAX_OUT = 4;

  logic              clk;
  logic              rst_n;
  logic              fft_start;
  logic              fft_busy;
  logic              fft_done;
  logic              rd_en;
  logic [LOG2_N-1:0] rd_addr_a;
  logic [LOG2_N-1:0] rd_addr_b;
  logic [LOG2_N-2:0] twdl_addr;
  logic              but_sample_rdy;
  logic              but_res_rdy;
  logic              wr_en;
  logic [LOG2_N-1:0] wr_addr;
  logic              but_ovrflw;
  logic              but_underflw;
  logic              seq_err;

  but_wing_seq #(
    .LOG2_N(LOG2_N),
    .P_RD_LAT(P_RD_LAT),
    .P_MAX_OUT(P_MAX_OUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fft_start(fft_start),
    .fft_busy(fft_busy),
    .fft_done(fft_done),
    .rd_en(rd_en),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .twdl_addr(twdl_addr),
    .but_sample_rdy(but_sample_rdy),
    .but_res_rdy(but_res_rdy),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .but_ovrflw(but_ovrflw),
    .but_underflw(but_underflw),
    .seq_err(seq_err)
  );

  typedef struct {
    int a;
    int b;
    int tw;
    int stage;
  } rd_exp_t;

  typedef struct {
    int addr;
    int stage;
  } wr_exp_t;

  rd_exp_t exp_rd[$];
  wr_exp_t exp_wr[$];
  int      lat_q[$];
  int      res_q[$];

  int tests;
  int fails;
  int cyc;
  int stall;
  int jitter;
  int last_end;
  int rd_total;
  int wr_total;
  int done_cnt;
  int mon_out;
  int last_rd;
  bit mon_beat;
  bit inject_res;
  bit inject_ovf;
  bit spurious;

  rd_exp_t mon_e;
  wr_exp_t mon_w;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference order of an in-place DIT FFT: per stage, per group, per position
  function automatic void push_expected();
    rd_exp_t e;
    wr_exp_t w;
    int      span;
    for (int s = 0; s < LOG2_N; s++) begin
      span = 1 << s;
      for (int g = 0; g < N / (2 * span); g++) begin
        for (int k = 0; k < span; k++) begin
          e.a     = g * 2 * span + k;
          e.b     = e.a + span;
          e.tw    = k * (N / (2 * span));
          e.stage = s;
          exp_rd.push_back(e);
          w.addr  = e.a;
          w.stage = s;
          exp_wr.push_back(w);
          w.addr  = e.b;
          exp_wr.push_back(w);
        end
      end
    end
  endfunction

  function automatic void resetModel();
    exp_rd.delete();
    exp_wr.delete();
    lat_q.delete();
    res_q.delete();
    last_end = 0;
    mon_out  = 0;
    mon_beat = 1'b0;
    rd_total = 0;
    wr_total = 0;
    done_cnt = 0;
  endfunction

  // One clock: drive inputs just after the edge and run the but_wing result model
  task automatic step(input logic start_v);
    int t;
    @(posedge clk);
    #1;
    cyc++;
    fft_start  = start_v;
    but_ovrflw = inject_ovf;
    inject_ovf = 1'b0;
    spurious   = 1'b0;
    if (inject_res) begin
      but_res_rdy = 1'b1;
      spurious    = 1'b1;
      inject_res  = 1'b0;
    end else if (res_q.size() > 0 && res_q[0] == cyc) begin
      but_res_rdy = 1'b1;
      void'(res_q.pop_front());
    end else begin
      but_res_rdy = 1'b0;
    end
    if (but_sample_rdy === 1'b1) begin
      t = cyc + 4 + stall + int'($urandom_range(0, jitter));
      if (t <= last_end) t = last_end + 1;
      res_q.push_back(t);
      res_q.push_back(t + 1);
      last_end = t + 1;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(fft_busy), 0);
    checkOutput({tag, "_done"}, 32'(fft_done), 0);
    checkOutput({tag, "_rd_en"}, 32'(rd_en), 0);
    checkOutput({tag, "_rd_addr_a"}, 32'(rd_addr_a), 0);
    checkOutput({tag, "_rd_addr_b"}, 32'(rd_addr_b), 0);
    checkOutput({tag, "_twdl"}, 32'(twdl_addr), 0);
    checkOutput({tag, "_sample_rdy"}, 32'(but_sample_rdy), 0);
    checkOutput({tag, "_wr_en"}, 32'(wr_en), 0);
    checkOutput({tag, "_wr_addr"}, 32'(wr_addr), 0);
    checkOutput({tag, "_seq_err"}, 32'(seq_err), 0);
  endtask

  task automatic midReset();
    @(posedge clk);
    #3;
    but_res_rdy = 1'b0;
    but_ovrflw  = 1'b0;
    fft_start   = 1'b0;
    rst_n       = 1'b0;
    #1;
    checkAllZero("mid_reset");
    resetModel();
    step(1'b0);
    step(1'b0);
    rst_n = 1'b1;
    step(1'b0);
    checkOutput("post_reset_busy", 32'(fft_busy), 0);
    checkOutput("post_reset_rd_en", 32'(rd_en), 0);
  endtask

  // mode 0: plain transform, 1: start pulse while busy, 2: overflow pulse, 3: reset mid-stage 1
  task automatic applyStimulus(input int stall_v, input int jit_v, input int mode);
    bit hit;
    int n;
    hit      = 1'b0;
    stall    = stall_v;
    jitter   = jit_v;
    rd_total = 0;
    wr_total = 0;
    done_cnt = 0;
    mon_out  = 0;
    mon_beat = 1'b0;
    push_expected();
    step(1'b1);
    step(1'b0);
    checkOutput("busy_after_start", 32'(fft_busy), 1);
    checkOutput("seq_err_cleared", 32'(seq_err), 0);
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      n++;
      if (mode == 1 && !hit && rd_total == 6) begin
        hit = 1'b1;
        step(1'b1);
      end else if (mode == 2 && !hit && rd_total == 3) begin
        hit        = 1'b1;
        inject_ovf = 1'b1;
        step(1'b0);
        step(1'b0);
        checkOutput("seq_err_ovf", 32'(seq_err), 1);
      end else if (mode == 3 && !hit && rd_total == 6) begin
        hit = 1'b1;
        midReset();
        return;
      end else begin
        step(1'b0);
      end
    end
    checkOutput("done_seen", done_cnt, 1);
    checkOutput("busy_after_done", 32'(fft_busy), 0);
    checkOutput("done_pulse_low", 32'(fft_done), 0);
    step(1'b0);
    step(1'b0);
    checkOutput("single_done", done_cnt, 1);
    checkOutput("rd_total", rd_total, LOG2_N * HALF);
    checkOutput("wr_total", wr_total, LOG2_N * N);
    checkOutput("rd_left", exp_rd.size(), 0);
    checkOutput("wr_left", exp_wr.size(), 0);
    checkOutput("seq_err_end", 32'(mode == 2), 32'(seq_err));
  endtask

  // Monitor: compare every DUT strobe against the scoreboard queues
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (rd_en === 1'b1) begin
          checkOutput("issue_gap", 32'((cyc - last_rd) >= 2), 1);
          checkOutput("max_outstanding", 32'(mon_out < P_MAX_OUT), 1);
          last_rd = cyc;
          mon_out++;
          rd_total++;
          lat_q.push_back(cyc);
          checkOutput("rd_expected", 32'(exp_rd.size() > 0), 1);
          if (exp_rd.size() > 0) begin
            mon_e = exp_rd.pop_front();
            checkOutput("rd_addr_a", 32'(rd_addr_a), mon_e.a);
            checkOutput("rd_addr_b", 32'(rd_addr_b), mon_e.b);
            checkOutput("twdl_addr", 32'(twdl_addr), mon_e.tw);
            checkOutput("stage_barrier", 32'(wr_total >= mon_e.stage * N), 1);
          end
        end
        if (but_sample_rdy === 1'b1) begin
          checkOutput("lat_pending", 32'(lat_q.size() > 0), 1);
          if (lat_q.size() > 0) checkOutput("sample_rdy_lat", cyc - lat_q.pop_front(), P_RD_LAT);
        end
        if (wr_en === 1'b1) begin
          if (spurious) begin
            checkOutput("wr_addr_spurious", 32'(wr_addr), 0);
          end else begin
            wr_total++;
            checkOutput("wr_expected", 32'(exp_wr.size() > 0), 1);
            if (exp_wr.size() > 0) begin
              mon_w = exp_wr.pop_front();
              checkOutput("wr_addr", 32'(wr_addr), mon_w.addr);
            end
            mon_beat = !mon_beat;
            if (!mon_beat) mon_out--;
          end
        end
        if (fft_done === 1'b1) done_cnt++;
      end
    end
  end

  initial begin
    tests        = 0;
    fails        = 0;
    cyc          = 0;
    last_rd      = -10;
    stall        = 0;
    jitter       = 0;
    inject_res   = 1'b0;
    inject_ovf   = 1'b0;
    spurious     = 1'b0;
    rst_n        = 1'b0;
    fft_start    = 1'b0;
    but_res_rdy  = 1'b0;
    but_ovrflw   = 1'b0;
    but_underflw = 1'b0;
    resetModel();
    #12;
    checkAllZero("por");
    step(1'b0);
    rst_n = 1'b1;
    step(1'b0);
    step(1'b0);

    $display("[TB] transform with fixed +6/+7 result latency");
    applyStimulus(0, 0, 0);
    repeat ($urandom_range(1, 4)) step(1'b0);

    $display("[TB] transform with results stalled by 20 cycles");
    applyStimulus(20, 0, 0);

    for (int i = 0; i < 2; i++) begin
      repeat ($urandom_range(1, 4)) step(1'b0);
      applyStimulus(int'($urandom_range(0, 8)), 3, 0);
    end

    $display("[TB] start pulse while busy");
    applyStimulus(int'($urandom_range(0, 6)), 2, 1);

    $display("[TB] spurious result in idle");
    inject_res = 1'b1;
    step(1'b0);
    step(1'b0);
    checkOutput("seq_err_spurious", 32'(seq_err), 1);
    step(1'b0);
    checkOutput("seq_err_sticky", 32'(seq_err), 1);

    $display("[TB] overflow during transform");
    applyStimulus(int'($urandom_range(0, 6)), 2, 2);
    repeat ($urandom_range(1, 4)) step(1'b0);

    $display("[TB] reset during stage 1, then clean transform");
    applyStimulus(int'($urandom_range(0, 6)), 1, 3);
    applyStimulus(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
